// File: rtl/cv32e40p_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cv32e40p_wb_arbiter_if
// Bundles the result-source handshake, register-file write ports and the
// ID-stage pending-write lookup of the write-back arbiter.
//   src_valid_i / src_ready_o   : per-source result handshake
//   src_waddr_i / src_wdata_i   : per-source destination register and result
//   wp_we_o / wp_waddr_o /
//   wp_wdata_o / wp_src_o       : register-file write ports and granted source
//   pend_raddr_i / pend_hit_o   : ID read addresses and buffered-write hits
// Signal suffixes are from the arbiter's point of view. The arbiter uses the
// slave modport; the producer/consumer side uses master.
// ---------------------------------------------------------------------------
interface cv32e40p_wb_arbiter_if #(
  parameter int NUM_SRC    = 3,
  parameter int NUM_WPORTS = 2,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);

  logic [NUM_SRC-1:0]                 src_valid_i;
  logic [NUM_SRC-1:0]                 src_ready_o;
  logic [NUM_SRC-1:0][ADDR_W-1:0]     src_waddr_i;
  logic [NUM_SRC-1:0][DATA_W-1:0]     src_wdata_i;

  logic [NUM_WPORTS-1:0]              wp_we_o;
  logic [NUM_WPORTS-1:0][ADDR_W-1:0]  wp_waddr_o;
  logic [NUM_WPORTS-1:0][DATA_W-1:0]  wp_wdata_o;
  logic [NUM_WPORTS-1:0][SRC_W-1:0]   wp_src_o;

  logic [2:0][ADDR_W-1:0]             pend_raddr_i;
  logic [2:0]                         pend_hit_o;

  modport slave (
    input  src_valid_i, src_waddr_i, src_wdata_i, pend_raddr_i,
    output src_ready_o, wp_we_o, wp_waddr_o, wp_wdata_o, wp_src_o, pend_hit_o
  );

  modport master (
    output src_valid_i, src_waddr_i, src_wdata_i, pend_raddr_i,
    input  src_ready_o, wp_we_o, wp_waddr_o, wp_wdata_o, wp_src_o, pend_hit_o
  );

endinterface

// File: rtl/cv32e40p_wb_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_wb_arbiter
// Register-file write-back arbiter. Each result source owns a DEPTH-entry
// FIFO of {waddr, wdata}. Every cycle a round-robin scan starting at rr_ptr
// hands up to NUM_WPORTS FIFO heads to the register-file write ports and pops
// them at the clock edge. Buffered destinations are exported to ID so it can
// hold off dependent instructions.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush_i             : drop every buffered write and this cycle's inputs
//   wb (slave)          : source handshake, write ports, pending-write lookup
//   busy_o              : any FIFO holds an entry
//   perf_contention_o   : a non-empty FIFO went without a grant this cycle
// ---------------------------------------------------------------------------
module cv32e40p_wb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int NUM_WPORTS = 2,
  parameter int DEPTH      = 2,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  cv32e40p_wb_arbiter_if.slave  wb,
  output logic                  busy_o,
  output logic                  perf_contention_o
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FIFO storage and control
  logic [ADDR_W-1:0] mem_waddr_q [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] mem_wdata_q [NUM_SRC][DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q    [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr_q    [NUM_SRC];
  logic [CNT_W-1:0]  count_q     [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr_q;
  logic [SRC_W-1:0]  rr_ptr_d;

  logic [NUM_SRC-1:0]             nonempty;
  logic [NUM_SRC-1:0]             ready;
  logic [NUM_SRC-1:0]             push;
  logic [NUM_SRC-1:0]             grant;
  logic [NUM_SRC-1:0][ADDR_W-1:0] head_waddr;
  logic [NUM_SRC-1:0][DATA_W-1:0] head_wdata;

  // Internal port bookkeeping is always two wide so NUM_WPORTS=1 needs no
  // special casing; only the first NUM_WPORTS entries reach the outputs.
  logic [1:0]             port_vld;
  logic [1:0][SRC_W-1:0]  port_src;
  logic [1:0][ADDR_W-1:0] port_waddr;

  logic                   entry_vld [NUM_SRC][DEPTH];
  logic [2:0]             pend_hit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [SRC_W-1:0] src_inc(input logic [SRC_W-1:0] s);
    return (s == SRC_W'(NUM_SRC - 1)) ? '0 : s + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // FIFO status
  // -------------------------------------------------------------------------
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      nonempty[s]   = (count_q[s] != '0);
      ready[s]      = (count_q[s] != CNT_W'(DEPTH)) & ~flush_i;
      push[s]       = wb.src_valid_i[s] & ready[s];
      head_waddr[s] = mem_waddr_q[s][rd_ptr_q[s]];
      head_wdata[s] = mem_wdata_q[s][rd_ptr_q[s]];
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin arbitration. Port 1 may not take a head with the same
  // destination as port 0; that head simply waits for a later cycle, which
  // keeps the two writes of one cycle free of address collisions.
  // -------------------------------------------------------------------------
  always_comb begin
    int idx;
    grant      = '0;
    port_vld   = '0;
    port_src   = '0;
    port_waddr = '0;
    idx        = 0;
    if (!flush_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        if (nonempty[idx]) begin
          if (!port_vld[0]) begin
            port_vld[0]   = 1'b1;
            port_src[0]   = SRC_W'(idx);
            port_waddr[0] = head_waddr[idx];
            grant[idx]    = 1'b1;
          end else if ((NUM_WPORTS > 1) && !port_vld[1] &&
                       (head_waddr[idx] != port_waddr[0])) begin
            port_vld[1]   = 1'b1;
            port_src[1]   = SRC_W'(idx);
            port_waddr[1] = head_waddr[idx];
            grant[idx]    = 1'b1;
          end
        end
      end
    end
  end

  // Pointer moves past the last source served in scan order.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (port_vld[1]) begin
      rr_ptr_d = src_inc(port_src[1]);
    end else if (port_vld[0]) begin
      rr_ptr_d = src_inc(port_src[0]);
    end
  end

  // -------------------------------------------------------------------------
  // Write-port and status outputs
  // -------------------------------------------------------------------------
  always_comb begin
    wb.src_ready_o = ready;
    wb.wp_we_o     = '0;
    wb.wp_waddr_o  = '0;
    wb.wp_wdata_o  = '0;
    wb.wp_src_o    = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (port_vld[p]) begin
        wb.wp_we_o[p]    = 1'b1;
        wb.wp_waddr_o[p] = head_waddr[port_src[p]];
        wb.wp_wdata_o[p] = head_wdata[port_src[p]];
        wb.wp_src_o[p]   = port_src[p];
      end
    end
  end

  assign busy_o            = |nonempty;
  assign perf_contention_o = ~flush_i & (|(nonempty & ~grant));

  // -------------------------------------------------------------------------
  // Pending-write lookup over stored entries only. An entry is live when its
  // distance from the read pointer is below the occupancy.
  // -------------------------------------------------------------------------
  always_comb begin
    int off;
    off = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        off = e - int'(rd_ptr_q[s]);
        if (off < 0) off = off + DEPTH;
        entry_vld[s][e] = (off < int'(count_q[s]));
      end
    end
  end

  always_comb begin
    pend_hit = '0;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (entry_vld[s][e] && (mem_waddr_q[s][e] == wb.pend_raddr_i[k])) begin
            pend_hit[k] = 1'b1;
          end
        end
      end
    end
  end

  assign wb.pend_hit_o = pend_hit;

  // -------------------------------------------------------------------------
  // FIFO control state. A flush empties every FIFO but leaves rr_ptr alone so
  // fairness carries across the flush.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
      rr_ptr_q <= '0;
    end else if (flush_i) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (push[s])  wr_ptr_q[s] <= ptr_inc(wr_ptr_q[s]);
        if (grant[s]) rd_ptr_q[s] <= ptr_inc(rd_ptr_q[s]);
        case ({push[s], grant[s]})
          2'b10:   count_q[s] <= count_q[s] + 1'b1;
          2'b01:   count_q[s] <= count_q[s] - 1'b1;
          default: count_q[s] <= count_q[s];
        endcase
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Entry payload needs no reset: nothing reads a slot outside the live range.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        mem_waddr_q[s][wr_ptr_q[s]] <= wb.src_waddr_i[s];
        mem_wdata_q[s][wr_ptr_q[s]] <= wb.src_wdata_i[s];
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
module tb_cv32e40p_wb_arbiter;

  localparam int NUM_SRC    = 3;
  localparam int NUM_WPORTS = 2;
  localparam int DEPTH      = 2;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy, cont;

  int errors = 0;
  int checks = 0;

  cv32e40p_wb_arbiter_if #(.NUM_SRC(NUM_SRC), .NUM_WPORTS(NUM_WPORTS),
                           .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

  cv32e40p_wb_arbiter #(.NUM_SRC(NUM_SRC), .NUM_WPORTS(NUM_WPORTS), .DEPTH(DEPTH),
                        .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .wb(wb),
    .busy_o(busy), .perf_contention_o(cont)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: accepted writes per source, popped when a port writes them.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t sb_q [NUM_SRC][$];

  always @(negedge clk) begin
    int   s;
    ent_t e;
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) sb_q[i].delete();
    end else begin
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (wb.wp_we_o[p]) begin
          s = int'(wb.wp_src_o[p]);
          if (s >= NUM_SRC || sb_q[s].size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected: port %0d src %0d addr %0h, no write expected",
                     p, s, wb.wp_waddr_o[p]);
          end else begin
            e = sb_q[s].pop_front();
            chk($sformatf("sb_addr p%0d s%0d", p, s), 64'(wb.wp_waddr_o[p]), 64'(e.a));
            chk($sformatf("sb_data p%0d s%0d", p, s), 64'(wb.wp_wdata_o[p]), 64'(e.d));
          end
        end else begin
          chk($sformatf("idle_port_zero p%0d", p),
              64'({wb.wp_waddr_o[p], wb.wp_wdata_o[p], wb.wp_src_o[p]}), 64'd0);
        end
      end
      if (&wb.wp_we_o) chk("port_addr_distinct", 64'(wb.wp_waddr_o[0] != wb.wp_waddr_o[1]), 64'd1);
      if (flush) begin
        chk("flush_no_we", 64'(wb.wp_we_o), 64'd0);
        for (int i = 0; i < NUM_SRC; i++) sb_q[i].delete();
      end else begin
        for (int i = 0; i < NUM_SRC; i++)
          if (wb.src_valid_i[i] && wb.src_ready_o[i])
            sb_q[i].push_back('{a: wb.src_waddr_i[i], d: wb.src_wdata_i[i]});
      end
    end
  end

  // Directed vectors: inputs of a cycle and outputs expected in that same cycle.
  typedef struct {
    logic [2:0]             v;
    logic [2:0][ADDR_W-1:0] a;
    logic [1:0]             we;
    logic [1:0][ADDR_W-1:0] wa;
    logic [1:0][1:0]        ws;
    logic                   busy;
    logic                   cont;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v, input int a2, input int a1, input int a0,
                              input logic [1:0] we, input int wa1, input int wa0,
                              input int ws1, input int ws0, input logic b, input logic c);
    vec_t r;
    r.v = v;
    r.a[2] = ADDR_W'(a2); r.a[1] = ADDR_W'(a1); r.a[0] = ADDR_W'(a0);
    r.we = we;
    r.wa[1] = ADDR_W'(wa1); r.wa[0] = ADDR_W'(wa0);
    r.ws[1] = 2'(ws1); r.ws[0] = 2'(ws0);
    r.busy = b; r.cont = c;
    return r;
  endfunction

  task automatic idle_inputs();
    wb.src_valid_i  = '0;
    wb.src_waddr_i  = '0;
    wb.src_wdata_i  = '0;
    wb.pend_raddr_i = '0;
    flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drive(input int s, input int a, input logic [DATA_W-1:0] d);
    wb.src_valid_i[s] = 1'b1;
    wb.src_waddr_i[s] = ADDR_W'(a);
    wb.src_wdata_i[s] = d;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    idle_inputs();
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_busy_clear"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({name, "_sb_empty"}, 64'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size()), 64'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t tv [18];

  initial begin
    tv[0]  = mk(3'b001, 0, 0, 5,   2'b00, 0, 0,  0, 0, 1'b0, 1'b0);
    tv[1]  = mk(3'b000, 0, 0, 0,   2'b01, 0, 5,  0, 0, 1'b1, 1'b0);
    tv[2]  = mk(3'b100, 9, 0, 0,   2'b00, 0, 0,  0, 0, 1'b0, 1'b0);
    tv[3]  = mk(3'b000, 0, 0, 0,   2'b01, 0, 9,  0, 2, 1'b1, 1'b0);
    tv[4]  = mk(3'b111, 3, 2, 1,   2'b00, 0, 0,  0, 0, 1'b0, 1'b0);
    tv[5]  = mk(3'b000, 0, 0, 0,   2'b11, 2, 1,  1, 0, 1'b1, 1'b1);
    tv[6]  = mk(3'b000, 0, 0, 0,   2'b01, 0, 3,  0, 2, 1'b1, 1'b0);
    tv[7]  = mk(3'b011, 0, 7, 7,   2'b00, 0, 0,  0, 0, 1'b0, 1'b0);
    tv[8]  = mk(3'b000, 0, 0, 0,   2'b01, 0, 7,  0, 0, 1'b1, 1'b1);
    tv[9]  = mk(3'b000, 0, 0, 0,   2'b01, 0, 7,  0, 1, 1'b1, 1'b0);
    tv[10] = mk(3'b111, 8, 4, 4,   2'b00, 0, 0,  0, 0, 1'b0, 1'b0);
    tv[11] = mk(3'b000, 0, 0, 0,   2'b11, 4, 8,  0, 2, 1'b1, 1'b1);
    tv[12] = mk(3'b000, 0, 0, 0,   2'b01, 0, 4,  0, 1, 1'b1, 1'b0);
    tv[13] = mk(3'b111, 6, 10, 6,  2'b00, 0, 0,  0, 0, 1'b0, 1'b0);
    tv[14] = mk(3'b000, 0, 0, 0,   2'b11, 10, 6, 1, 2, 1'b1, 1'b1);
    tv[15] = mk(3'b001, 0, 0, 11,  2'b01, 0, 6,  0, 0, 1'b1, 1'b0);
    tv[16] = mk(3'b000, 0, 0, 0,   2'b01, 0, 11, 0, 0, 1'b1, 1'b0);
    tv[17] = mk(3'b000, 0, 0, 0,   2'b00, 0, 0,  0, 0, 1'b0, 1'b0);

    // Reset values
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_we", 64'(wb.wp_we_o), 64'd0);
    chk("rst_wp_fields", 64'({wb.wp_waddr_o, wb.wp_src_o}), 64'd0);
    chk("rst_wdata", 64'(wb.wp_wdata_o), 64'd0);
    chk("rst_ready", 64'(wb.src_ready_o), 64'b111);
    chk("rst_pend_hit", 64'(wb.pend_hit_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cont", 64'(cont), 64'd0);
    next_cycle();
    rst_n = 1'b1;

    // Table-driven directed vectors
    for (int r = 0; r < 18; r++) begin
      idle_inputs();
      for (int s = 0; s < NUM_SRC; s++)
        if (tv[r].v[s]) drive(s, int'(tv[r].a[s]), 32'hA5A5_0001 + 32'(r << 8) + 32'(s));
      @(negedge clk);
      chk($sformatf("r%0d_we", r), 64'(wb.wp_we_o), 64'(tv[r].we));
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (tv[r].we[p]) begin
          chk($sformatf("r%0d_waddr%0d", r, p), 64'(wb.wp_waddr_o[p]), 64'(tv[r].wa[p]));
          chk($sformatf("r%0d_src%0d", r, p), 64'(wb.wp_src_o[p]), 64'(tv[r].ws[p]));
        end
      end
      chk($sformatf("r%0d_busy", r), 64'(busy), 64'(tv[r].busy));
      chk($sformatf("r%0d_cont", r), 64'(cont), 64'(tv[r].cont));
      chk($sformatf("r%0d_ready", r), 64'(wb.src_ready_o), 64'b111);
      next_cycle();
    end
    drain("table");

    // Pending-write lookup
    idle_inputs();
    drive(1, 12, 32'h0000_0C0C);
    wb.pend_raddr_i[0] = 6'd3;
    wb.pend_raddr_i[1] = 6'd12;
    wb.pend_raddr_i[2] = 6'd13;
    @(negedge clk);
    chk("pend_not_on_inputs", 64'(wb.pend_hit_o), 64'b000);
    next_cycle();
    wb.src_valid_i = '0;
    @(negedge clk);
    chk("pend_hit_buffered", 64'(wb.pend_hit_o), 64'b010);
    next_cycle();
    @(negedge clk);
    chk("pend_hit_after_write", 64'(wb.pend_hit_o), 64'b000);
    next_cycle();

    // Backpressure on source 2 while equal addresses serialise the ports
    do_reset();
    drive(0, 20, 32'hB000_0000);
    drive(1, 20, 32'hB000_0001);
    drive(2, 20, 32'hC000_0000);
    @(negedge clk);
    chk("bp_ready_start", 64'(wb.src_ready_o), 64'b111);
    next_cycle();
    idle_inputs();
    drive(2, 20, 32'hC000_0001);
    @(negedge clk);
    chk("bp_c1_we", 64'({wb.wp_we_o, wb.wp_src_o[0]}), 64'({2'b01, 2'd0}));
    chk("bp_c1_ready2", 64'(wb.src_ready_o[2]), 64'd1);
    next_cycle();
    drive(2, 20, 32'hC000_0002);
    @(negedge clk);
    chk("bp_c2_full", 64'(wb.src_ready_o[2]), 64'd0);
    chk("bp_c2_we", 64'({wb.wp_we_o, wb.wp_src_o[0]}), 64'({2'b01, 2'd1}));
    next_cycle();
    @(negedge clk);
    chk("bp_c3_full", 64'(wb.src_ready_o[2]), 64'd0);
    chk("bp_c3_we", 64'({wb.wp_we_o, wb.wp_src_o[0]}), 64'({2'b01, 2'd2}));
    next_cycle();
    @(negedge clk);
    chk("bp_c4_ready_after_pop", 64'(wb.src_ready_o[2]), 64'd1);
    chk("bp_c4_we", 64'({wb.wp_we_o, wb.wp_src_o[0]}), 64'({2'b01, 2'd2}));
    next_cycle();
    drain("bp");

    // Flush with four buffered entries; rr_ptr must survive it
    idle_inputs();
    for (int s = 0; s < NUM_SRC; s++) drive(s, 30, 32'hF000_0000 + 32'(s));
    next_cycle();
    idle_inputs();
    drive(0, 30, 32'hF000_0010);
    drive(1, 30, 32'hF000_0011);
    @(negedge clk);
    chk("fl_pre_we", 64'({wb.wp_we_o, wb.wp_src_o[0]}), 64'({2'b01, 2'd0}));
    next_cycle();
    idle_inputs();
    for (int s = 0; s < NUM_SRC; s++) drive(s, 31, 32'hDEAD_0000);
    wb.pend_raddr_i = {6'd30, 6'd30, 6'd30};
    flush = 1'b1;
    @(negedge clk);
    chk("fl_we_zero", 64'(wb.wp_we_o), 64'd0);
    chk("fl_ready_low", 64'(wb.src_ready_o), 64'b000);
    chk("fl_busy_during", 64'(busy), 64'd1);
    chk("fl_pend_before", 64'(wb.pend_hit_o), 64'b111);
    next_cycle();
    idle_inputs();
    wb.pend_raddr_i = {6'd30, 6'd30, 6'd30};
    @(negedge clk);
    chk("fl_busy_after", 64'(busy), 64'd0);
    chk("fl_we_after", 64'(wb.wp_we_o), 64'd0);
    chk("fl_ready_after", 64'(wb.src_ready_o), 64'b111);
    chk("fl_pend_after", 64'(wb.pend_hit_o), 64'b000);
    next_cycle();
    idle_inputs();
    drive(0, 40, 32'h4000_0000);
    drive(1, 41, 32'h4000_0001);
    drive(2, 42, 32'h4000_0002);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("fl_rr_kept", 64'({wb.wp_we_o, wb.wp_src_o[1], wb.wp_src_o[0]}),
        64'({2'b11, 2'd2, 2'd1}));
    next_cycle();
    drain("flush");

    // Asynchronous reset with entries buffered
    idle_inputs();
    drive(0, 50, 32'h5000_0000);
    drive(1, 51, 32'h5000_0001);
    drive(2, 52, 32'h5000_0002);
    wb.pend_raddr_i = {6'd52, 6'd51, 6'd50};
    next_cycle();
    wb.src_valid_i = '0;
    chk("ar_pend_before", 64'(wb.pend_hit_o), 64'b111);
    chk("ar_busy_before", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_we", 64'(wb.wp_we_o), 64'd0);
    chk("ar_wp_fields", 64'({wb.wp_waddr_o, wb.wp_src_o}), 64'd0);
    chk("ar_ready", 64'(wb.src_ready_o), 64'b111);
    chk("ar_pend", 64'(wb.pend_hit_o), 64'b000);
    chk("ar_cont", 64'(cont), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_wb_arbiter.md
# cv32e40p_wb_arbiter

Parametrised register-file write-back arbiter for the EX/WB boundary. It generalises the fixed ALU-port/LSU-port write muxing to NUM_SRC result sources (ALU/MUL, LSU, APU, CSR, future accelerators) and NUM_WPORTS register-file write ports. Sources no longer stall on write-port contention: each source has a small FIFO, and a round-robin arbiter drains up to NUM_WPORTS FIFO heads per cycle. It also exports pending-write status to ID for hazard detection.

## Interface
- NUM_SRC, 3, number of result sources (2..8)
- NUM_WPORTS, 2, register-file write ports (1..2, ≤ NUM_SRC)
- DEPTH, 2, entries per source FIFO (1..4, any integer)
- ADDR_W, 6, write address width (GPR + FPR space)
- DATA_W, 32, write data width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered writes
- src_valid_i  in  NUM_SRC  source has a result
- src_ready_o  out  NUM_SRC  source FIFO can accept
- src_waddr_i  in  NUM_SRC×ADDR_W  destination register per source
- src_wdata_i  in  NUM_SRC×DATA_W  result per source
- wp_we_o  out  NUM_WPORTS  write-port enable
- wp_waddr_o  out  NUM_WPORTS×ADDR_W  write-port address
- wp_wdata_o  out  NUM_WPORTS×DATA_W  write-port data
- wp_src_o  out  NUM_WPORTS×$clog2(NUM_SRC)  granted source index per port
- pend_raddr_i  in  3×ADDR_W  ID-stage read addresses to check
- pend_hit_o  out  3  read address matches any buffered entry
- busy_o  out  1  any FIFO non-empty
- perf_contention_o  out  1  a non-empty source was not granted this cycle

## Operation
- Per source: FIFO of DEPTH {waddr, wdata} entries, read/write pointers wrapping at DEPTH, occupancy counter 0..DEPTH.
- Enqueue on src_valid_i & src_ready_o; src_ready_o = (count != DEPTH) & ~flush_i; no same-cycle pop credit.
- Arbitration every cycle over non-empty FIFOs, scanning circularly from rr_ptr:
  - port 0 gets first non-empty source;
  - port 1 (if NUM_WPORTS=2) gets next non-empty source whose head waddr ≠ port 0's waddr; an equal-address head is skipped and waits.
- Granted heads are popped at the clock edge; wp_we_o high for exactly those ports; ungranted ports drive we=0, waddr/wdata/src = 0.
- rr_ptr ← (index of last granted source + 1) mod NUM_SRC; unchanged when nothing granted.
- Per-source order is FIFO order; no ordering across sources is guaranteed (ID must use pend_hit_o to protect RAW/WAW).
- pend_hit_o[k] = any valid entry in any FIFO with waddr == pend_raddr_i[k] (combinational over stored entries, not over this-cycle inputs).
- perf_contention_o = 1 when at least one non-empty FIFO received no grant.
- flush_i: all counts/pointers cleared at the edge, no writes issued that cycle (wp_we_o = 0), inputs that cycle dropped, rr_ptr kept.

## Timing
- Reset: all FIFOs empty, rr_ptr = 0, wp_we_o = 0, wp_waddr_o/wp_wdata_o/wp_src_o = 0, src_ready_o = all 1, pend_hit_o = 0, busy_o = 0, perf_contention_o = 0.
- Latency: result accepted in cycle N appears on a write port no earlier than N+1 (no bypass).
- Outputs depend only on registered FIFO state and rr_ptr (plus pend_raddr_i for pend_hit_o); no src_valid_i → wp_* path.
- Full FIFO: src_ready_o low; pop in cycle N raises src_ready_o in N+1.
- Empty→push→pop: count 0→1→0; simultaneous push and pop on same FIFO keeps count constant.
- Reset asserted mid-operation: buffered writes lost, outputs return to reset values asynchronously.

## Test plan
- Single source 0 pushes {waddr=5, wdata=0xA5A5_0001} at cycle 0 → wp_we_o[0]=1, waddr 5, data 0xA5A5_0001, wp_src_o[0]=0 at cycle 1; busy_o=0 at cycle 2.
- NUM_SRC=3, NUM_WPORTS=2, all three push distinct addresses 1,2,3 same cycle → cycle 1 grants src 0,1 (rr_ptr→2), cycle 2 grants src 2, perf_contention_o=1 in cycle 1 only.
- Sources 0 and 1 heads both waddr=7 → only src 0 written in cycle 1, src 1 in cycle 2; never two ports with equal address in one cycle.
- DEPTH=2, source 2 pushes 3 back-to-back while blocked by higher-load sources → src_ready_o[2]=0 after 2 accepted; third accepted only after a pop; data order preserved.
- Buffered entry waddr=12, pend_raddr_i[1]=12 → pend_hit_o=3'b010; after its write cycle → 0.
- flush_i with 4 buffered entries → next cycle busy_o=0, wp_we_o=0 during flush cycle, src_ready_o all 1; reset asserted with entries buffered → immediate reset values.
